// File: rtl/inst_queue_dual_dec_if.sv
// Fetch-to-decode bundle for inst_queue_dual_dec: push lanes from fetch,
// issue slots and back-pressure toward the pair of main decoders.
//   master: fetch/decode side (drives pushes and issue_ready)
//   slave : the instruction queue itself
interface inst_queue_dual_dec_if #(
   parameter int FETCH_W = 2,
   parameter int DEPTH   = 16
);
   logic [FETCH_W-1:0]      in_valid;
   logic [32*FETCH_W-1:0]   in_inst;
   logic [32*FETCH_W-1:0]   in_pc;
   logic                    in_ready;
   logic                    issue_ready;
   logic [1:0]              out_valid;
   logic [31:0]             out_inst0;
   logic [31:0]             out_inst1;
   logic [31:0]             out_pc0;
   logic [31:0]             out_pc1;
   logic                    out_in_ds1;
   logic [$clog2(DEPTH):0]  count;

   modport master (
      output in_valid, in_inst, in_pc, issue_ready,
      input  in_ready, out_valid, out_inst0, out_inst1,
      input  out_pc0, out_pc1, out_in_ds1, count
   );

   modport slave (
      input  in_valid, in_inst, in_pc, issue_ready,
      output in_ready, out_valid, out_inst0, out_inst1,
      output out_pc0, out_pc1, out_in_ds1, count
   );
endinterface

// File: rtl/inst_queue_dual_dec.sv
// Instruction queue between fetch and decode with push-time pre-decode
// and MIPS dual-issue pairing.
//   clk, resetn (sync, active low), flush (clears queue at next edge)
//   q: inst_queue_dual_dec_if.slave -- push lanes, issue slots, count
module inst_queue_dual_dec #(
   parameter int DEPTH      = 16,
   parameter int FETCH_W    = 2,
   parameter int DUAL_ISSUE = 1
) (
   input logic clk,
   input logic resetn,
   input logic flush,
   inst_queue_dual_dec_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic       br;
      logic       mem;
      logic       md;
      logic       priv;
      logic [4:0] dst;
   } cls_t;

   // Unrecognised encodings are classed priv so they always issue alone.
   function automatic cls_t predec(input logic [31:0] w);
      cls_t       c;
      logic       rsv;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      op  = w[31:26];
      rs  = w[25:21];
      rt  = w[20:16];
      rd  = w[15:11];
      fn  = w[5:0];
      c   = '0;
      rsv = 1'b0;
      case (op)
         6'h00: begin
            c.dst = rd;
            case (fn)
               6'h08, 6'h09: c.br = 1'b1;
               6'h0c, 6'h0d: c.priv = 1'b1;
               6'h10, 6'h11, 6'h12, 6'h13,
               6'h18, 6'h19, 6'h1a, 6'h1b: c.md = 1'b1;
               6'h30, 6'h31, 6'h32, 6'h33,
               6'h34, 6'h36: c.priv = 1'b1;
               6'h00, 6'h02, 6'h03, 6'h04,
               6'h06, 6'h07, 6'h0a, 6'h0b,
               6'h0f, 6'h20, 6'h21, 6'h22,
               6'h23, 6'h24, 6'h25, 6'h26,
               6'h27, 6'h2a, 6'h2b: ;
               default: rsv = 1'b1;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00, 5'h01: c.br = 1'b1;
               5'h10, 5'h11: begin
                  c.br  = 1'b1;
                  c.dst = 5'd31;
               end
               5'h08, 5'h09, 5'h0a,
               5'h0b, 5'h0c, 5'h0e: c.priv = 1'b1;
               default: rsv = 1'b1;
            endcase
         end
         6'h02, 6'h04, 6'h05,
         6'h06, 6'h07: c.br = 1'b1;
         6'h03: begin
            c.br  = 1'b1;
            c.dst = 5'd31;
         end
         6'h08, 6'h09, 6'h0a, 6'h0b,
         6'h0c, 6'h0d, 6'h0e, 6'h0f: c.dst = rt;
         6'h10: begin
            c.priv = 1'b1;
            if (rs == 5'd0) c.dst = rt;
         end
         6'h1c: begin
            c.dst = rd;
            case (fn)
               6'h00, 6'h01, 6'h02,
               6'h04, 6'h05: c.md = 1'b1;
               6'h20, 6'h21: ;
               default: rsv = 1'b1;
            endcase
         end
         6'h1f: begin
            case (fn)
               6'h00, 6'h04: c.dst = rt;
               6'h20: c.dst = rd;
               default: rsv = 1'b1;
            endcase
         end
         6'h20, 6'h21, 6'h22, 6'h23,
         6'h24, 6'h25, 6'h26, 6'h30: begin
            c.mem = 1'b1;
            c.dst = rt;
         end
         6'h28, 6'h29, 6'h2a, 6'h2b,
         6'h2e, 6'h38: c.mem = 1'b1;
         6'h2f: c.priv = 1'b1;
         default: rsv = 1'b1;
      endcase
      if (rsv) c.priv = 1'b1;
      return c;
   endfunction

   cls_t        cls_q  [DEPTH];
   logic [31:0] inst_q [DEPTH];
   logic [31:0] pc_q   [DEPTH];

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] push_n, pop_n;
   logic [AW-1:0] h1;
   logic          rdy;
   logic          s0v, s1v, blk, raw;
   cls_t          c0, c1;
   logic [31:0]   i0, i1;

   // Full check ignores same-cycle pop on purpose: keeps in_ready off
   // the issue path.
   assign rdy = (count_q <= CW'(DEPTH - FETCH_W));

   always_comb begin
      push_n = '0;
      for (int k = 0; k < FETCH_W; k++)
         if (rdy && q.in_valid[k]) push_n = push_n + CW'(1);
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_W; k++) begin
         if (rdy && q.in_valid[k]) begin
            inst_q[tail_q + AW'(k)] <= q.in_inst[32*k +: 32];
            pc_q[tail_q + AW'(k)]   <= q.in_pc[32*k +: 32];
            cls_q[tail_q + AW'(k)]  <= predec(q.in_inst[32*k +: 32]);
         end
      end
   end

   assign h1 = head_q + AW'(1);
   assign c0 = cls_q[head_q];
   assign c1 = cls_q[h1];
   assign i0 = inst_q[head_q];
   assign i1 = inst_q[h1];

   always_comb begin
      raw = (c0.dst != 5'd0) &&
            ((c0.dst == i1[25:21]) || (c0.dst == i1[20:16]));
      blk = c0.priv | c1.priv | c0.md | c1.md |
            (c0.mem & c1.mem) | c1.br | raw;
      // A lone branch waits for its delay slot.
      s0v = (count_q >= CW'(1)) && !(c0.br && (count_q == CW'(1)));
      s1v = (DUAL_ISSUE != 0) && (count_q >= CW'(2)) && !blk;
   end

   assign q.in_ready   = rdy;
   assign q.count      = count_q;
   assign q.out_valid  = {s1v, s0v};
   assign q.out_inst0  = s0v ? i0 : '0;
   assign q.out_pc0    = s0v ? pc_q[head_q] : '0;
   assign q.out_inst1  = s1v ? i1 : '0;
   assign q.out_pc1    = s1v ? pc_q[h1] : '0;
   assign q.out_in_ds1 = c0.br & s1v;

   always_comb begin
      pop_n   = q.issue_ready ? (CW'(s0v) + CW'(s1v)) : '0;
      head_d  = head_q + pop_n[AW-1:0];
      tail_d  = tail_q + push_n[AW-1:0];
      count_d = count_q + push_n - pop_n;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_inst_queue_dual_dec.sv
// Directed bench for inst_queue_dual_dec: pairing table, branch hold,
// fill/wrap ordering, flush and reset. A DUAL_ISSUE=0 copy shadows it.
module tb_inst_queue_dual_dec;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic flush = 1'b0;

   inst_queue_dual_dec_if #(.FETCH_W(2), .DEPTH(16)) a ();
   inst_queue_dual_dec_if #(.FETCH_W(2), .DEPTH(16)) b ();

   inst_queue_dual_dec #(.DEPTH(16), .FETCH_W(2), .DUAL_ISSUE(1)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .q(a.slave));
   inst_queue_dual_dec #(.DEPTH(16), .FETCH_W(2), .DUAL_ISSUE(0)) dut1 (
      .clk(clk), .resetn(resetn), .flush(flush), .q(b.slave));

   assign b.in_valid    = a.in_valid;
   assign b.in_inst     = a.in_inst;
   assign b.in_pc       = a.in_pc;
   assign b.issue_ready = a.issue_ready;

   always #5 clk = ~clk;

   localparam logic [31:0] ADDU3  = 32'h0022_1821;
   localparam logic [31:0] ORI5   = 32'h3485_0001;
   localparam logic [31:0] ADDIU8 = 32'h2408_0001;
   localparam logic [31:0] ADDU9  = 32'h0108_4821;
   localparam logic [31:0] BEQ    = 32'h1000_0004;
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] LW2    = 32'h8C22_0000;
   localparam logic [31:0] SW3    = 32'hAC23_0004;
   localparam logic [31:0] SW3B   = 32'hAC23_0000;
   localparam logic [31:0] MULT   = 32'h0022_0018;
   localparam logic [31:0] ADDU4  = 32'h00A6_2021;
   localparam logic [31:0] ADDU7  = 32'h00A6_3821;
   localparam logic [31:0] MFC0   = 32'h4004_6000;
   localparam logic [31:0] BNE    = 32'h14A6_0003;
   localparam logic [31:0] JAL    = 32'h0C00_0010;
   localparam logic [31:0] SYSC   = 32'h0000_000C;
   localparam logic [31:0] ADDU0  = 32'h0022_0021;
   localparam logic [31:0] ADDU40 = 32'h0000_2021;

   typedef struct {
      logic [1:0]  iv;
      logic [31:0] i0;
      logic [31:0] i1;
      logic [1:0]  ov;
      logic        ds;
      logic [4:0]  cnt;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   int ncmp = 0;
   int nerr = 0;
   int g = 0;
   logic [31:0] pcq [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] iv,
                       input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
      a.in_valid = iv;
      a.in_inst  = {i1, i0};
      a.in_pc    = {p1, p0};
      cyc();
      a.in_valid = '0;
   endtask

   function automatic logic [31:0] gen_inst(input int n);
      logic [31:0] r;
      r = 32'h2400_0000;
      r[20:16] = 5'((n % 8) + 1);
      r[15:0]  = 16'(n);
      return r;
   endfunction

   // acc=0 marks a push that must be refused: poisoned PCs, not queued.
   task automatic push_gen(input logic [1:0] iv, input bit acc);
      logic [31:0] p0, p1;
      p0 = acc ? 32'h8000_0000 + 32'(4 * g) : 32'hDEAD_0000;
      p1 = acc ? 32'h8000_0004 + 32'(4 * g) : 32'hDEAD_0004;
      if (acc) begin
         pcq.push_back(p0);
         if (iv[1]) pcq.push_back(p1);
      end
      push(iv, gen_inst(g), p0, gen_inst(g + 1), p1);
      if (acc) g += iv[1] ? 2 : 1;
   endtask

   task automatic drain(input int n, input string nm);
      int seen = 0;
      int bud = 0;
      a.issue_ready = 1'b1;
      while (seen < n && bud < 64) begin
         if (a.out_valid[0] && seen < n) begin
            chk(nm, a.out_pc0, pcq.pop_front());
            seen++;
         end
         if (a.out_valid[1] && seen < n) begin
            chk(nm, a.out_pc1, pcq.pop_front());
            seen++;
         end
         bud++;
         cyc();
      end
      a.issue_ready = 1'b0;
      ncmp++;
      if (seen < n) begin
         nerr++;
         $display("FAIL %s timeout: drained %0d want %0d", nm, seen, n);
      end
      chk({nm, " cnt"}, 32'(a.count), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{2'b11, ADDU3,  ORI5,   2'b11, 1'b0, 5'd2};
      tbl[1]  = '{2'b11, ADDIU8, ADDU9,  2'b01, 1'b0, 5'd2};
      tbl[2]  = '{2'b11, LW2,    SW3,    2'b01, 1'b0, 5'd2};
      tbl[3]  = '{2'b11, MULT,   ADDU4,  2'b01, 1'b0, 5'd2};
      tbl[4]  = '{2'b11, MFC0,   ADDU7,  2'b01, 1'b0, 5'd2};
      tbl[5]  = '{2'b11, ADDU3,  BNE,    2'b01, 1'b0, 5'd2};
      tbl[6]  = '{2'b01, BEQ,    NOP,    2'b00, 1'b0, 5'd1};
      tbl[7]  = '{2'b11, BEQ,    NOP,    2'b11, 1'b1, 5'd2};
      tbl[8]  = '{2'b11, NOP,    MULT,   2'b01, 1'b0, 5'd2};
      tbl[9]  = '{2'b11, SYSC,   NOP,    2'b01, 1'b0, 5'd2};
      tbl[10] = '{2'b11, JAL,    NOP,    2'b11, 1'b1, 5'd2};
      tbl[11] = '{2'b11, ADDU3,  SW3B,   2'b01, 1'b0, 5'd2};
      tbl[12] = '{2'b11, ADDU0,  ADDU40, 2'b11, 1'b0, 5'd2};
      tbl[13] = '{2'b11, LW2,    ADDU4,  2'b11, 1'b0, 5'd2};
      tbl[14] = '{2'b01, ADDU4,  NOP,    2'b01, 1'b0, 5'd1};

      a.in_valid = '0;
      a.in_inst = '0;
      a.in_pc = '0;
      a.issue_ready = 1'b0;
      cyc();
      cyc();
      chk("rst cnt", 32'(a.count), 32'd0);
      chk("rst ov", 32'(a.out_valid), 32'd0);
      chk("rst rdy", 32'(a.in_ready), 32'd1);
      chk("rst pc0", a.out_pc0, 32'd0);
      resetn = 1'b1;

      push(2'b11, ADDU3, 32'hBFC0_0000, ORI5, 32'hBFC0_0004);
      chk("pair ov", 32'(a.out_valid), 32'd3);
      chk("pair pc1", a.out_pc1, 32'hBFC0_0004);
      chk("pair cnt", 32'(a.count), 32'd2);
      a.issue_ready = 1'b1;
      cyc();
      a.issue_ready = 1'b0;
      chk("pair pop cnt", 32'(a.count), 32'd0);
      chk("pair pop ov", 32'(a.out_valid), 32'd0);

      push(2'b11, ADDIU8, 32'h100, ADDU9, 32'h104);
      chk("raw ov", 32'(a.out_valid), 32'd1);
      chk("raw i0", a.out_inst0, ADDIU8);
      a.issue_ready = 1'b1;
      cyc();
      chk("raw2 ov", 32'(a.out_valid), 32'd1);
      chk("raw2 i0", a.out_inst0, ADDU9);
      chk("raw2 cnt", 32'(a.count), 32'd1);
      cyc();
      chk("raw3 cnt", 32'(a.count), 32'd0);

      push(2'b01, BEQ, 32'h200, NOP, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("hold%0d ov", i), 32'(a.out_valid), 32'd0);
         chk($sformatf("hold%0d cnt", i), 32'(a.count), 32'd1);
         cyc();
      end
      push(2'b01, NOP, 32'h204, NOP, 32'h0);
      chk("ds ov", 32'(a.out_valid), 32'd3);
      chk("ds flag", 32'(a.out_in_ds1), 32'd1);
      chk("ds pc1", a.out_pc1, 32'h204);
      cyc();
      chk("ds pop cnt", 32'(a.count), 32'd0);
      a.issue_ready = 1'b0;

      push(2'b11, ADDU3, 32'h300, ORI5, 32'h304);
      a.issue_ready = 1'b1;
      push(2'b11, ADDU3, 32'h308, ORI5, 32'h30C);
      chk("pp cnt", 32'(a.count), 32'd2);
      chk("pp pc0", a.out_pc0, 32'h308);
      cyc();
      a.issue_ready = 1'b0;
      chk("pp2 cnt", 32'(a.count), 32'd0);

      flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int v = 0; v < NV; v++) begin
         logic [31:0] pc;
         pc = 32'h9000_0000 + 32'(v * 16);
         push(tbl[v].iv, tbl[v].i0, pc, tbl[v].i1, pc + 4);
         chk($sformatf("t%0d ov", v), 32'(a.out_valid), 32'(tbl[v].ov));
         chk($sformatf("t%0d ds", v), 32'(a.out_in_ds1), 32'(tbl[v].ds));
         chk($sformatf("t%0d cnt", v), 32'(a.count), 32'(tbl[v].cnt));
         chk($sformatf("t%0d pc0", v), a.out_pc0,
             tbl[v].ov[0] ? pc : 32'd0);
         chk($sformatf("t%0d i1", v), a.out_inst1,
             tbl[v].ov[1] ? tbl[v].i1 : 32'd0);
         chk($sformatf("t%0d si ov", v), 32'(b.out_valid),
             32'({1'b0, tbl[v].ov[0]}));
         flush = 1'b1;
         cyc();
         flush = 1'b0;
      end

      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      for (int i = 0; i < 7; i++) push_gen(2'b11, 1'b1);
      chk("fill14 rdy", 32'(a.in_ready), 32'd1);
      push_gen(2'b01, 1'b1);
      chk("fill15 cnt", 32'(a.count), 32'd15);
      chk("fill15 rdy", 32'(a.in_ready), 32'd0);
      push_gen(2'b11, 1'b0);
      chk("fill15 drop", 32'(a.count), 32'd15);
      drain(15, "drainA");
      for (int i = 0; i < 8; i++) push_gen(2'b11, 1'b1);
      chk("fill16 cnt", 32'(a.count), 32'd16);
      chk("fill16 rdy", 32'(a.in_ready), 32'd0);
      drain(16, "drainB");
      for (int i = 0; i < 8; i++) push_gen(2'b11, 1'b1);
      drain(16, "drainC");

      for (int i = 0; i < 4; i++) push_gen(2'b11, 1'b1);
      push_gen(2'b01, 1'b1);
      chk("fl cnt9", 32'(a.count), 32'd9);
      flush = 1'b1;
      a.in_valid = 2'b11;
      #1;
      chk("fl same ov", 32'(a.out_valid), 32'd3);
      cyc();
      flush = 1'b0;
      a.in_valid = '0;
      chk("fl cnt", 32'(a.count), 32'd0);
      chk("fl ov", 32'(a.out_valid), 32'd0);
      pcq.delete();

      for (int i = 0; i < 2; i++) push_gen(2'b11, 1'b1);
      chk("rs pre cnt", 32'(a.count), 32'd4);
      resetn = 1'b0;
      a.issue_ready = 1'b1;
      a.in_valid = 2'b11;
      cyc();
      resetn = 1'b1;
      a.issue_ready = 1'b0;
      a.in_valid = '0;
      chk("rs cnt", 32'(a.count), 32'd0);
      chk("rs ov", 32'(a.out_valid), 32'd0);
      chk("rs rdy", 32'(a.in_ready), 32'd1);
      chk("rs pc0", a.out_pc0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
